// File: rtl/pmem_responder.sv
// Line-wide physical-memory responder for the L2 cache: one request at a time,
// fixed programmable latency, plus saturating transaction counters and a sticky protocol-error flag.
module pmem_responder #(
  parameter int LATENCY    = 10,
  parameter int INDEX_BITS = 12,
  parameter int LINE_BITS  = 128
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 pmem_read,
  input  logic                 pmem_write,
  input  logic [15:0]          pmem_address,
  input  logic [LINE_BITS-1:0] pmem_wdata,
  output logic                 pmem_resp,
  output logic [LINE_BITS-1:0] pmem_rdata,
  output logic                 busy,
  output logic                 proto_err,
  output logic [15:0]          rd_count,
  output logic [15:0]          wr_count
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [LINE_BITS-1:0]  mem [2**INDEX_BITS];

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  op_wr_q, op_wr_d;
  logic [INDEX_BITS-1:0] idx_q, idx_d;
  logic [LINE_BITS-1:0]  wdata_q, wdata_d;
  logic [LINE_BITS-1:0]  rdata_q, rdata_d;
  logic                  perr_q, perr_d;
  logic [15:0]           rd_cnt_q, rd_cnt_d;
  logic [15:0]           wr_cnt_q, wr_cnt_d;
  logic                  mem_we;
  logic [INDEX_BITS-1:0] req_idx;
  logic                  addr_unused;

  // Offset bits and bits above the index alias onto the same line by design.
  assign req_idx     = pmem_address[4 +: INDEX_BITS];
  assign addr_unused = ^pmem_address;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_wr_d  = op_wr_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    perr_d   = perr_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    mem_we   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pmem_read || pmem_write) begin
          op_wr_d = pmem_write;
          idx_d   = req_idx;
          wdata_d = pmem_wdata;
          cnt_d   = CNT_INIT;
          if (pmem_read && pmem_write) perr_d = 1'b1;
          if (LATENCY == 1) begin
            state_d = S_RESP;
            if (!pmem_write) rdata_d = mem[req_idx];
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = S_RESP;
          if (!op_wr_q) rdata_d = mem[idx_q];
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        mem_we  = op_wr_q;
        if (op_wr_q) wr_cnt_d = sat_inc(wr_cnt_q);
        else         rd_cnt_d = sat_inc(rd_cnt_q);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      rdata_q  <= '0;
      perr_q   <= 1'b0;
      rd_cnt_q <= 16'd0;
      wr_cnt_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      perr_q   <= perr_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Latched request and backing array hold data only; reset leaves them alone.
  always_ff @(posedge clk) begin
    op_wr_q <= op_wr_d;
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
    if (mem_we) mem[idx_q] <= wdata_q;
  end

  assign pmem_resp  = (state_q == S_RESP);
  assign busy       = (state_q != S_IDLE);
  assign pmem_rdata = rdata_q;
  assign proto_err  = perr_q;
  assign rd_count   = rd_cnt_q;
  assign wr_count   = wr_cnt_q;

endmodule

// File: tb/tb_pmem_responder.sv
// Bench for pmem_responder: a LATENCY=10 instance driven with directed and random traffic
// against a line-array reference model, and a LATENCY=1 instance for latency-1 and counter saturation.
module tb_pmem_responder;
  localparam int L  = 10;
  localparam int IB = 12;
  localparam int LB = 128;

  typedef struct {
    logic            wr;
    logic [LB-1:0]   data;
    int              at;
  } exp_t;

  // Main instance
  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          pmem_read = 1'b0, pmem_write = 1'b0;
  logic [15:0]   pmem_address = '0;
  logic [LB-1:0] pmem_wdata = '0;
  logic          pmem_resp, busy, proto_err;
  logic [LB-1:0] pmem_rdata;
  logic [15:0]   rd_count, wr_count;

  // Latency-1 instance
  logic          clk1 = 1'b0;
  logic          reset_n1 = 1'b1;
  logic          pmem_read1 = 1'b0, pmem_write1 = 1'b0;
  logic [15:0]   pmem_address1 = '0;
  logic [LB-1:0] pmem_wdata1 = '0;
  logic          pmem_resp1, busy1, proto_err1;
  logic [LB-1:0] pmem_rdata1;
  logic [15:0]   rd_count1, wr_count1;

  pmem_responder #(.LATENCY(L), .INDEX_BITS(IB), .LINE_BITS(LB)) dut (
    .clk(clk), .reset_n(reset_n), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp),
    .pmem_rdata(pmem_rdata), .busy(busy), .proto_err(proto_err),
    .rd_count(rd_count), .wr_count(wr_count));

  pmem_responder #(.LATENCY(1), .INDEX_BITS(4), .LINE_BITS(LB)) dut1 (
    .clk(clk1), .reset_n(reset_n1), .pmem_read(pmem_read1), .pmem_write(pmem_write1),
    .pmem_address(pmem_address1), .pmem_wdata(pmem_wdata1), .pmem_resp(pmem_resp1),
    .pmem_rdata(pmem_rdata1), .busy(busy1), .proto_err(proto_err1),
    .rd_count(rd_count1), .wr_count(wr_count1));

  always #5 clk = ~clk;
  always #2 clk1 = ~clk1;

  int cyc = 0;
  int cyc1 = 0;
  always @(posedge clk)  cyc  <= cyc + 1;
  always @(posedge clk1) cyc1 <= cyc1 + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [LB-1:0] got, input logic [LB-1:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Reference model: memory contents by line index plus expected observable state
  logic [LB-1:0] ref_mem [int];
  int            exp_rd = 0, exp_wr = 0;
  logic          exp_perr = 1'b0;
  logic [LB-1:0] exp_rdata = '0;
  int            busy_from = -1, busy_to = -2;
  exp_t          sbq[$];
  logic          mon_en = 1'b0;
  logic          done1 = 1'b0;
  exp_t          mon_e;

  // Scoreboard monitor
  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", busy, (cyc >= busy_from && cyc <= busy_to));
      if (pmem_resp) begin
        if (sbq.size() == 0) begin
          chk("unexpected_resp", pmem_resp, 0);
        end else begin
          mon_e = sbq.pop_front();
          chk("resp_cycle", cyc, mon_e.at);
          if (!mon_e.wr) chk("rdata", pmem_rdata, mon_e.data);
        end
      end else if (sbq.size() > 0 && cyc >= sbq[0].at) begin
        mon_e = sbq.pop_front();
        chk("resp_missing", pmem_resp, 1);
      end
    end
  end

  // Issue one transaction in the current (idle) cycle; returns in the idle cycle after resp.
  task automatic xact(input logic rd, input logic wr, input logic [15:0] addr,
                      input logic [LB-1:0] wd, input int hold, input logic scramble);
    exp_t e;
    int   t;
    int   idx;
    idx = int'(addr[4 +: IB]);
    t   = cyc;
    pmem_read    = rd;
    pmem_write   = wr;
    pmem_address = addr;
    pmem_wdata   = wd;
    e.at = t + L;
    e.wr = wr;
    if (wr) begin
      ref_mem[idx] = wd;
      e.data = wd;
      exp_wr = (exp_wr < 65535) ? exp_wr + 1 : exp_wr;
    end else begin
      e.data = ref_mem[idx];
      exp_rdata = e.data;
      exp_rd = (exp_rd < 65535) ? exp_rd + 1 : exp_rd;
    end
    if (rd && wr) exp_perr = 1'b1;
    sbq.push_back(e);
    busy_from = t + 1;
    busy_to   = t + L;
    for (int k = 1; k <= hold; k++) begin
      @(posedge clk); #1;
      if (k == 1 && scramble) begin
        pmem_address = 16'($urandom);
        pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
      end
      if (k == hold) begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
      end
    end
    while (cyc < t + L + 1) begin
      @(posedge clk); #1;
    end
    chk("rd_count", rd_count, exp_rd);
    chk("wr_count", wr_count, exp_wr);
    chk("proto_err", proto_err, exp_perr);
    chk("rdata_hold", pmem_rdata, exp_rdata);
  endtask

  task automatic reset_abort_test();
    int t;
    xact(0, 1, 16'h0080, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666, L, 0);
    t = cyc;
    pmem_write   = 1'b1;
    pmem_address = 16'h0080;
    pmem_wdata   = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
    busy_from = t + 1;
    busy_to   = t + L;
    while (cyc < t + 5) begin
      @(posedge clk); #1;
    end
    busy_to    = t + 4;
    reset_n    = 1'b0;
    pmem_write = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    repeat (2) begin @(posedge clk); #1; end
    reset_n   = 1'b1;
    exp_rd    = 0;
    exp_wr    = 0;
    exp_perr  = 1'b0;
    exp_rdata = '0;
    chk("abort_rd_count", rd_count, 0);
    chk("abort_wr_count", wr_count, 0);
    chk("abort_proto_err", proto_err, 0);
    chk("abort_rdata", pmem_rdata, 0);
    repeat (L + 2) begin @(posedge clk); #1; end
    xact(1, 0, 16'h0085, '0, L, 0);
  endtask

  initial begin
    logic [LB-1:0] d1;
    logic [15:0]   pool [8];
    int            r, gap;
    d1 = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_resp", pmem_resp, 0);
    chk("rst_rdata", pmem_rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_rd_count", rd_count, 0);
    chk("rst_wr_count", wr_count, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    xact(0, 1, 16'h1230, d1, L, 0);
    xact(1, 0, 16'h1234, '0, L, 0);
    xact(0, 1, 16'h2000, {$urandom, $urandom, $urandom, $urandom}, L, 0);
    xact(1, 0, 16'h123F, '0, L, 0);
    xact(1, 0, 16'h2009, '0, 3, 1);
    xact(0, 1, 16'h0710, {$urandom, $urandom, $urandom, $urandom}, 2, 1);
    xact(1, 0, 16'h0717, '0, 1, 1);
    xact(1, 1, 16'h0040, {$urandom, $urandom, $urandom, $urandom}, L, 0);
    xact(1, 0, 16'h0040, '0, 2, 0);
    xact(0, 1, 16'h1230, d1, L, 0);
    reset_abort_test();

    for (int i = 0; i < 8; i++) begin
      pool[i] = 16'($urandom) & 16'hFFF0;
      xact(0, 1, pool[i] | 16'($urandom_range(0, 15)),
           {$urandom, $urandom, $urandom, $urandom}, $urandom_range(1, L), 1'($urandom));
    end
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 7);
      xact(r < 4 || r == 7, r >= 4, pool[$urandom_range(0, 7)] | 16'($urandom_range(0, 15)),
           {$urandom, $urandom, $urandom, $urandom}, $urandom_range(1, L), 1'($urandom));
      gap = $urandom_range(0, 2);
      repeat (gap) begin @(posedge clk); #1; end
    end

    for (int i = 0; i < 200000 && !done1; i++) @(posedge clk);
    chk("l1_done", done1, 1);
    chk("queue_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Latency-1 instance: resp one cycle after accept, aliasing above the index, counter saturation
  initial begin
    logic [LB-1:0] d2;
    int            t, pulses, w;
    d2 = 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978;
    #1 reset_n1 = 1'b0;
    repeat (2) @(posedge clk1);
    #1 reset_n1 = 1'b1;
    @(posedge clk1); #1;
    t = cyc1;
    pmem_write1   = 1'b1;
    pmem_address1 = 16'h0030;
    pmem_wdata1   = d2;
    @(posedge clk1); #1;
    pmem_write1 = 1'b0;
    @(negedge clk1);
    chk("l1_write_resp", pmem_resp1, 1);
    chk("l1_write_cycle", cyc1, t + 1);
    @(negedge clk1);
    chk("l1_resp_width", pmem_resp1, 0);
    chk("l1_wr_count", wr_count1, 1);
    @(posedge clk1); #1;
    t = cyc1;
    pmem_read1    = 1'b1;
    pmem_address1 = 16'hAB3F;
    pulses = 0;
    while (pulses < 65536) begin
      w = 0;
      @(negedge clk1);
      while (!pmem_resp1 && w < 4) begin
        @(negedge clk1);
        w++;
      end
      if (!pmem_resp1) begin
        chk("l1_resp_timeout", pmem_resp1, 1);
        break;
      end
      pulses++;
      if (pulses == 1) begin
        chk("l1_read_cycle", cyc1, t + 1);
        chk("l1_rdata_alias", pmem_rdata1, d2);
      end
      @(negedge clk1);
      if (pulses == 65536) pmem_read1 = 1'b0;
      if (pulses inside {1, 1000, 65534, 65535, 65536})
        chk("l1_rd_count", rd_count1, (pulses > 65535) ? 65535 : pulses);
    end
    repeat (3) @(negedge clk1);
    chk("l1_idle_after", pmem_resp1, 0);
    chk("l1_rd_count_sat", rd_count1, 16'hFFFF);
    done1 = 1'b1;
  end

endmodule
